dmem_copy_engine: RTL and testbench

- Initiator-side master for the single-cycle data memory port. It drives Address, WriteData, MemoryRead and MemoryWrite, and consumes ReadData.
- Performs a block copy of N 64-bit words from a source byte address to a destination byte address.
- Sits beside the CPU datapath and owns the data-memory port only while Busy=1; the top level muxes port ownership on Busy.

---
 rtl/dmem_copy_engine_if.sv | 39 +++
 rtl/dmem_copy_engine.sv | 160 ++++++++++++++++
 tb/tb_dmem_copy_engine.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_copy_engine_if.sv
// dmem_copy_engine_if: single-cycle data memory port.
//
// Signals
//   Address      byte address, driven by the initiator
//   WriteData    64-bit store data, driven by the initiator
//   MemoryRead   read enable, driven by the initiator
//   MemoryWrite  write enable, driven by the initiator; memory commits on the rising edge
//   ReadData     combinational load data, driven by the memory
//
// Modports
//   master  initiator side (the copy engine or the CPU datapath)
//   slave   memory side
interface dmem_copy_engine_if #(
  parameter int unsigned ADDR_W = 64
);

  logic [ADDR_W-1:0] Address;
  logic [63:0]       WriteData;
  logic              MemoryRead;
  logic              MemoryWrite;
  logic [63:0]       ReadData;

  modport master (
    output Address,
    output WriteData,
    output MemoryRead,
    output MemoryWrite,
    input  ReadData
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemoryRead,
    input  MemoryWrite,
    output ReadData
  );

endinterface

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: block copy of N 64-bit words between two aligned byte addresses
// over the single-cycle data memory port. One word costs exactly one READ cycle and
// one WRITE cycle; the copy runs in ascending address order.
//
// Ports
//   Clock        rising-edge clock shared with the data memory
//   Reset_n      asynchronous active-low reset
//   Start        one-cycle request, sampled only in IDLE
//   Abort        ends the transfer after any in-flight write completes
//   SrcAddr      source byte address (8-byte aligned)
//   DstAddr      destination byte address (8-byte aligned)
//   WordCount    number of 64-bit words to copy
//   mem          data memory port (master side)
//   Busy         high while the engine owns the memory port (READ/WRITE)
//   Done         one-cycle pulse at transfer end
//   Error        sticky misalignment flag, cleared by the next accepted Start
//   WordsCopied  words written by the last transfer, held after DONE
module dmem_copy_engine #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [ADDR_W-1:0]    SrcAddr,
  input  logic [ADDR_W-1:0]    DstAddr,
  input  logic [CNT_W-1:0]     WordCount,
  dmem_copy_engine_if.master   mem,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [CNT_W-1:0]     WordsCopied
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] WordBytes = ADDR_W'(8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [63:0]       buffer_q, buffer_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  copied_q, copied_d;

  logic [ADDR_W-1:0] address;
  logic [63:0]       write_data;
  logic              memory_read;
  logic              memory_write;
  logic              misaligned;

  assign misaligned = (|SrcAddr[2:0]) || (|DstAddr[2:0]);

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      buffer_q    <= '0;
      error_q     <= 1'b0;
      copied_q    <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
      error_q     <= error_d;
      copied_q    <= copied_d;
    end
  end

  // Next-state logic and memory controls. The controls decode straight from state_q,
  // so an asynchronous reset drops MemoryWrite immediately and a read and a write can
  // never be requested in the same cycle.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remaining_d  = remaining_q;
    buffer_d     = buffer_q;
    error_d      = error_q;
    copied_d     = copied_q;
    address      = '0;
    write_data   = '0;
    memory_read  = 1'b0;
    memory_write = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (misaligned) begin
            // Reject without touching memory; WordsCopied keeps its last value.
            error_d = 1'b1;
            state_d = StDone;
          end else if (WordCount == '0) begin
            error_d  = 1'b0;
            copied_d = '0;
            state_d  = StDone;
          end else begin
            src_d       = SrcAddr;
            dst_d       = DstAddr;
            remaining_d = WordCount;
            error_d     = 1'b0;
            copied_d    = '0;
            state_d     = StRead;
          end
        end
      end

      StRead: begin
        address     = src_q;
        memory_read = 1'b1;
        buffer_d    = mem.ReadData;
        src_d       = src_q + WordBytes;
        // Abort here leaves the fetched word unwritten.
        state_d     = Abort ? StDone : StWrite;
      end

      StWrite: begin
        address      = dst_q;
        write_data   = buffer_q;
        memory_write = 1'b1;
        dst_d        = dst_q + WordBytes;
        remaining_d  = remaining_q - 1'b1;
        copied_d     = copied_q + 1'b1;
        // The write commits on this edge regardless of Abort.
        state_d      = (remaining_q == CNT_W'(1) || Abort) ? StDone : StRead;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem.Address     = address;
  assign mem.WriteData   = write_data;
  assign mem.MemoryRead  = memory_read;
  assign mem.MemoryWrite = memory_write;

  assign Busy        = (state_q == StRead) || (state_q == StWrite);
  assign Done        = (state_q == StDone);
  assign Error       = error_q;
  assign WordsCopied = copied_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: directed bench for dmem_copy_engine with a 128-word
// behavioural data memory (index = Address[9:3]).
module tb_dmem_copy_engine;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 64;

  logic              Clock;
  logic              Reset_n;
  logic              Start;
  logic              Abort;
  logic [ADDR_W-1:0] SrcAddr;
  logic [ADDR_W-1:0] DstAddr;
  logic [CNT_W-1:0]  WordCount;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [CNT_W-1:0]  WordsCopied;

  dmem_copy_engine_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_copy_engine #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Abort       (Abort),
    .SrcAddr     (SrcAddr),
    .DstAddr     (DstAddr),
    .WordCount   (WordCount),
    .mem         (bus.master),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error),
    .WordsCopied (WordsCopied)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural memory: combinational read, commit on rising edge.
  logic [63:0] mem [0:127];
  assign bus.ReadData = mem[bus.Address[9:3]];
  always @(posedge Clock) begin
    if (bus.MemoryWrite) mem[bus.Address[9:3]] = bus.WriteData;
  end

  // Port activity monitor.
  int rd_cnt;
  int wr_cnt;
  int both_cnt;
  always @(negedge Clock) begin
    if (bus.MemoryRead) rd_cnt++;
    if (bus.MemoryWrite) wr_cnt++;
    if (bus.MemoryRead && bus.MemoryWrite) both_cnt++;
  end

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fill(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  // Issues Start, optionally pulses Abort / a stray Start in given cycles after the
  // accepting edge, and returns the cycle number at which Done is seen.
  task automatic run_copy(input logic [63:0] src, input logic [63:0] dst,
                          input logic [15:0] cnt, input int abort_at, input int restart_at,
                          output int lat);
    rd_cnt    = 0;
    wr_cnt    = 0;
    SrcAddr   = src;
    DstAddr   = dst;
    WordCount = cnt;
    Start     = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    lat   = 1;
    while (!Done && lat < 100) begin
      check("busy", 64'(Busy), 64'd1);
      Abort = (lat == abort_at);
      Start = (lat == restart_at);
      @(posedge Clock);
      #1;
      lat++;
    end
    Abort = 1'b0;
    Start = 1'b0;
  endtask

  // Steps past the DONE cycle and checks the pulse is one cycle wide.
  task automatic finish_done();
    @(posedge Clock);
    #1;
    check("done_pulse", 64'(Done), 64'd0);
    check("idle_busy", 64'(Busy), 64'd0);
  endtask

  int lat;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    Start     = 1'b0;
    Abort     = 1'b0;
    SrcAddr   = '0;
    DstAddr   = '0;
    WordCount = '0;
    for (int i = 0; i < 128; i++) mem[i] = fill(i);
    mem[0] = 64'd1;
    mem[1] = 64'd10;
    mem[2] = 64'd5;
    mem[3] = 64'h0FFB_EA7D_EADB_EEFF;

    Reset_n = 1'b0;
    #23;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_error", 64'(Error), 64'd0);
    check("rst_copied", 64'(WordsCopied), 64'd0);
    check("rst_ctrl", {62'd0, bus.MemoryRead, bus.MemoryWrite}, 64'd0);
    check("rst_addr", bus.Address, 64'd0);
    check("rst_wdata", bus.WriteData, 64'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    // Basic copy: 4 words 0x00 -> 0x100.
    run_copy(64'h0, 64'h100, 16'd4, 0, 0, lat);
    check("basic_lat", 64'(lat), 64'd9);
    check("basic_copied", 64'(WordsCopied), 64'd4);
    check("basic_error", 64'(Error), 64'd0);
    check("basic_m32", mem[32], 64'd1);
    check("basic_m33", mem[33], 64'd10);
    check("basic_m34", mem[34], 64'd5);
    check("basic_m35", mem[35], 64'h0FFB_EA7D_EADB_EEFF);
    check("basic_m36", mem[36], fill(36));
    check("basic_rd", 64'(rd_cnt), 64'd4);
    check("basic_wr", 64'(wr_cnt), 64'd4);
    finish_done();

    // Zero count.
    run_copy(64'h0, 64'h180, 16'd0, 0, 0, lat);
    check("zero_lat", 64'(lat), 64'd1);
    check("zero_copied", 64'(WordsCopied), 64'd0);
    check("zero_rd", 64'(rd_cnt), 64'd0);
    check("zero_wr", 64'(wr_cnt), 64'd0);
    finish_done();

    // Misaligned source, then an aligned Start clears Error.
    run_copy(64'h4, 64'h300, 16'd2, 0, 0, lat);
    check("mis_lat", 64'(lat), 64'd1);
    check("mis_error", 64'(Error), 64'd1);
    check("mis_wr", 64'(wr_cnt), 64'd0);
    check("mis_m96", mem[96], fill(96));
    finish_done();
    check("mis_sticky", 64'(Error), 64'd1);
    run_copy(64'h18, 64'h300, 16'd1, 0, 0, lat);
    check("clr_lat", 64'(lat), 64'd3);
    check("clr_error", 64'(Error), 64'd0);
    check("clr_m96", mem[96], 64'h0FFB_EA7D_EADB_EEFF);
    finish_done();

    // Abort during the third WRITE (cycle 6 after acceptance).
    run_copy(64'h0, 64'h280, 16'd8, 6, 0, lat);
    check("abort_lat", 64'(lat), 64'd7);
    check("abort_copied", 64'(WordsCopied), 64'd3);
    check("abort_wr", 64'(wr_cnt), 64'd3);
    check("abort_m80", mem[80], 64'd1);
    check("abort_m82", mem[82], 64'd5);
    check("abort_m83", mem[83], fill(83));
    finish_done();

    // Reset asserted in the middle of a WRITE cycle.
    SrcAddr   = 64'h0;
    DstAddr   = 64'h200;
    WordCount = 16'd4;
    Start     = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    @(posedge Clock);
    #1;
    check("rmid_inwrite", 64'(bus.MemoryWrite), 64'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("rmid_wr", 64'(bus.MemoryWrite), 64'd0);
    check("rmid_busy", 64'(Busy), 64'd0);
    check("rmid_addr", bus.Address, 64'd0);
    check("rmid_wdata", bus.WriteData, 64'd0);
    @(posedge Clock);
    #1;
    check("rmid_m64", mem[64], fill(64));
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    run_copy(64'h0, 64'h200, 16'd2, 0, 0, lat);
    check("rrun_lat", 64'(lat), 64'd5);
    check("rrun_m64", mem[64], 64'd1);
    check("rrun_m65", mem[65], 64'd10);
    finish_done();

    // Overlapping ascending copy with a stray Start mid-transfer.
    run_copy(64'h0, 64'h8, 16'd3, 0, 3, lat);
    check("ovl_lat", 64'(lat), 64'd7);
    check("ovl_copied", 64'(WordsCopied), 64'd3);
    check("ovl_m1", mem[1], 64'd1);
    check("ovl_m2", mem[2], 64'd1);
    check("ovl_m3", mem[3], 64'd1);
    check("ovl_m4", mem[4], fill(4));
    finish_done();
    @(posedge Clock);
    #1;
    check("ovl_stay_idle", 64'(Busy), 64'd0);

    check("rd_wr_exclusive", 64'(both_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
